gpca_iter_unit: RTL

- Parametrised, sequential successor to the fixed 9-row combinational general-purpose cellular array.
- Evaluates one array row per clock on a single shared row datapath, for operand width W.
- Supports four modes: multiply, square, square root and divide.
- Ready/valid handshake on input and output; sits between the operand register file and the result writeback stage.

---
 rtl/gpca_pkg.sv | 17 +
 rtl/gpca_row.sv | 60 ++++++
 rtl/gpca_iter_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/gpca_pkg.sv
// Shared encodings for the iterative general-purpose cellular array unit.
package gpca_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_SQR  = 2'b01,
    OP_SQRT = 2'b10,
    OP_DIV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/gpca_row.sv
// One combinational array row: shift-add, non-restoring root or restoring divide step.
module gpca_row
  import gpca_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  op_e              mode,
  input  logic [2*W-1:0]   acc,
  input  logic [W+2:0]     part,
  input  logic [W-1:0]     root,
  input  logic [W-1:0]     opnd,
  output logic [2*W-1:0]   acc_nx,
  output logic [W+2:0]     part_nx,
  output logic             qbit
);

  localparam int unsigned PW = W + 3;

  logic [W:0]    mul_sum;
  logic [PW-1:0] sq_shift;
  logic [PW-1:0] sq_next;
  logic [W:0]    dv_t;
  logic [W:0]    dv_diff;
  logic          dv_ge;

  always_comb begin
    acc_nx  = acc;
    part_nx = part;
    qbit    = 1'b0;

    mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};

    // Partial remainder is two's complement; its sign picks subtract or add.
    sq_shift = {part[W:0], acc[2*W-1 -: 2]};
    sq_next  = part[PW-1] ? (sq_shift + {1'b0, root, 2'b11})
                          : (sq_shift - {1'b0, root, 2'b01});

    dv_t    = {part[W-1:0], acc[2*W-1]};
    dv_ge   = (dv_t >= {1'b0, opnd});
    dv_diff = dv_t - {1'b0, opnd};

    unique case (mode)
      OP_MUL, OP_SQR: begin
        acc_nx = {mul_sum, acc[W-1:1]};
      end
      OP_SQRT: begin
        acc_nx  = acc << 2;
        part_nx = sq_next;
        qbit    = ~sq_next[PW-1];
      end
      OP_DIV: begin
        acc_nx  = acc << 1;
        part_nx = {2'b00, (dv_ge ? dv_diff : dv_t)};
        qbit    = dv_ge;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/gpca_iter_unit.sv
// Sequential cellular array: one row per clock for MUL/SQR/SQRT/DIV with ready/valid.
module gpca_iter_unit
  import gpca_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [2*W-1:0]   opa,
  input  logic [W-1:0]     opb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   res,
  output logic [W:0]       rem,
  output logic             dz,
  output logic             ovf
);

  localparam int unsigned PW = W + 3;
  localparam int unsigned CW = $clog2(W);

  state_e          state;
  op_e             mode_q;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc_q;
  logic [PW-1:0]   part_q;
  logic [W-1:0]    quo_q;
  logic [W-1:0]    opnd_q;
  logic            dz_q;
  logic            ovf_q;

  logic [2*W-1:0]  acc_nx;
  logic [PW-1:0]   part_nx;
  logic            qbit;
  logic [W-1:0]    q_nx;
  logic [W:0]      sq_fix;
  logic [2*W-1:0]  res_nx;
  logic [W:0]      rem_nx;

  gpca_row #(.W(W)) u_row (
    .mode    (mode_q),
    .acc     (acc_q),
    .part    (part_q),
    .root    (quo_q),
    .opnd    (opnd_q),
    .acc_nx  (acc_nx),
    .part_nx (part_nx),
    .qbit    (qbit)
  );

  // Result formatting for the final row, including the root remainder correction.
  always_comb begin
    q_nx   = {quo_q[W-2:0], qbit};
    sq_fix = part_nx[W:0] + {q_nx, 1'b1};
    res_nx = '0;
    rem_nx = '0;
    unique case (mode_q)
      OP_MUL, OP_SQR: res_nx = acc_nx;
      OP_SQRT: begin
        res_nx = {{W{1'b0}}, q_nx};
        rem_nx = part_nx[PW-1] ? sq_fix : part_nx[W:0];
      end
      OP_DIV: begin
        if (dz_q || ovf_q) begin
          res_nx = '1;
        end else begin
          res_nx = {{W{1'b0}}, q_nx};
          rem_nx = {1'b0, part_nx[W-1:0]};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= StIdle;
      mode_q    <= OP_MUL;
      cnt       <= '0;
      acc_q     <= '0;
      part_q    <= '0;
      quo_q     <= '0;
      opnd_q    <= '0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      res       <= '0;
      rem       <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            state    <= StRun;
            in_ready <= 1'b0;
            cnt      <= CW'(W - 1);
            mode_q   <= op_e'(op);
            part_q   <= '0;
            quo_q    <= '0;
            dz_q     <= (op_e'(op) == OP_DIV) && (opb == '0);
            ovf_q    <= (op_e'(op) == OP_DIV) && (opb != '0) && (opa[2*W-1:W] >= opb);
            unique case (op_e'(op))
              OP_MUL: begin
                acc_q  <= {{W{1'b0}}, opb};
                opnd_q <= opa[W-1:0];
              end
              OP_SQR: begin
                acc_q  <= {{W{1'b0}}, opa[W-1:0]};
                opnd_q <= opa[W-1:0];
              end
              OP_SQRT: begin
                acc_q  <= opa;
                opnd_q <= '0;
              end
              OP_DIV: begin
                acc_q  <= {opa[W-1:0], {W{1'b0}}};
                part_q <= {3'b000, opa[2*W-1:W]};
                opnd_q <= opb;
              end
              default: ;
            endcase
          end
        end
        StRun: begin
          acc_q  <= acc_nx;
          part_q <= part_nx;
          quo_q  <= q_nx;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            state     <= StDone;
            out_valid <= 1'b1;
            res       <= res_nx;
            rem       <= rem_nx;
            dz        <= dz_q;
            ovf       <= ovf_q;
          end
        end
        StDone: begin
          if (out_ready) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
